// File: rtl/lane_cond_pkg.sv
// Shared lane mode codes, config FSM encoding and reset-mode helper for bit_lane_conditioner.
package lane_cond_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_TOG  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } cfg_state_e;

    // Low half of the lanes invert, high half pass; wide enough for WIDTH up to 8.
    function automatic logic [15:0] default_reset_mode(input int unsigned width);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < width / 2; i++) begin
            m[2*i +: 2] = MODE_INV;
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_cell.sv
// One registered data lane: pass, invert, hold or toggle-on-rising-edge of i_d.
module lane_cell
    import lane_cond_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic       i_d,
    output logic       o_q
);

    logic r_q;
    logic r_d_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q      <= 1'b0;
            r_d_prev <= 1'b0;
        end else begin
            // Edge history tracks the input in every mode so TOGGLE starts clean.
            r_d_prev <= i_d;
            case (i_mode)
                MODE_PASS: r_q <= i_d;
                MODE_INV:  r_q <= ~i_d;
                MODE_TOG:  r_q <= r_q ^ (i_d & ~r_d_prev);
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bit_lane_conditioner.sv
// WIDTH registered lanes with per-lane modes loaded MSB-first over a 2-pin serial config port.
module bit_lane_conditioner
    import lane_cond_pkg::*;
#(
    parameter int unsigned           WIDTH      = 4,
    parameter logic [2*WIDTH-1:0]    RESET_MODE = (2*WIDTH)'(default_reset_mode(WIDTH))
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_cfg_en,
    input  logic             i_cfg_sdi,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_cfg_busy,
    output logic             o_cfg_done,
    output logic             o_cfg_err
);

    localparam int unsigned   SHIFT_W   = 2 * WIDTH;
    localparam int unsigned   CNT_W     = $clog2(SHIFT_W + 2);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(SHIFT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SHIFT_W + 1);

    cfg_state_e          r_state;
    logic [SHIFT_W-1:0]  r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [SHIFT_W-1:0]  r_mode;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_mode  <= RESET_MODE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_en) begin
                        r_state <= ST_SHIFT;
                        r_shift <= {{(SHIFT_W-1){1'b0}}, i_cfg_sdi};
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_cfg_en) begin
                        r_shift <= {r_shift[SHIFT_W-2:0], i_cfg_sdi};
                        // Saturate one past a full frame so overlong frames stay rejected.
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        if (r_cnt == FRAME_LEN) begin
                            r_mode <= r_shift;
                            r_done <= 1'b1;
                            r_err  <= 1'b0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        lane_cell u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_mode (r_mode[2*g +: 2]),
            .i_d    (i_data_in[g]),
            .o_q    (o_data_out[g])
        );
    end

    assign o_cfg_busy = r_busy;
    assign o_cfg_done = r_done;
    assign o_cfg_err  = r_err;

endmodule

// File: tb/tb_bit_lane_conditioner.sv
// Directed self-checking bench for bit_lane_conditioner (WIDTH=4, default reset modes).
module tb_bit_lane_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       cfg_en;
    logic       cfg_sdi;
    logic [3:0] data_out;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    bit_lane_conditioner #(.WIDTH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data_in  (data_in),
        .i_cfg_en   (cfg_en),
        .i_cfg_sdi  (cfg_sdi),
        .o_data_out (data_out),
        .o_cfg_busy (cfg_busy),
        .o_cfg_done (cfg_done),
        .o_cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; one tick = one rising edge, then sample.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_en  = 1'b1;
            cfg_sdi = bits[i];
            tick();
        end
        cfg_sdi = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] tog_d [6];
    logic       tog_q [6];

    initial begin
        rst = 1'b1; data_in = 4'b0000; cfg_en = 1'b0; cfg_sdi = 1'b0;

        // 1: reset state, then RESET_MODE (lanes 1,0 invert) one clock later
        tick();
        check("rst_out",  8'(data_out), 8'h0);
        check("rst_busy", 8'(cfg_busy), 8'h0);
        check("rst_done", 8'(cfg_done), 8'h0);
        check("rst_err",  8'(cfg_err),  8'h0);
        rst = 1'b0;
        tick();
        check("post_rst_out", 8'(data_out), 8'h3);

        // 2: valid frame TOG,HOLD,INV,PASS
        send_bits(16'h00E4, 8);
        check("shift_busy", 8'(cfg_busy), 8'h1);
        check("shift_done", 8'(cfg_done), 8'h0);
        cfg_en = 1'b0;
        tick();
        check("commit_done", 8'(cfg_done), 8'h1);
        check("commit_err",  8'(cfg_err),  8'h0);
        check("commit_busy", 8'(cfg_busy), 8'h0);
        check("commit_out",  8'(data_out), 8'h3);
        data_in = 4'b0101;
        tick();
        check("mode_out",  8'(data_out), 8'h3);
        check("done_pulse", 8'(cfg_done), 8'h0);

        // 3: toggle lane sees rising edges of data_in[3]
        tog_d = '{4'b0101, 4'b1101, 4'b0101, 4'b1101, 4'b1101, 4'b0101};
        tog_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            data_in = tog_d[i];
            tick();
            check($sformatf("tog_%0d", i), 8'(data_out), 8'({tog_q[i], 3'b011}));
        end

        // 4: short and long frames rejected, then a valid frame clears the error
        send_bits(16'h0000, 7);
        cfg_en = 1'b0;
        tick();
        check("short_err",  8'(cfg_err),  8'h1);
        check("short_done", 8'(cfg_done), 8'h0);
        check("short_out",  8'(data_out), 8'h3);
        send_bits(16'h0000, 9);
        cfg_en = 1'b0;
        tick();
        check("long_err",  8'(cfg_err),  8'h1);
        check("long_done", 8'(cfg_done), 8'h0);
        check("long_out",  8'(data_out), 8'h3);
        send_bits(16'h00E4, 8);
        check("err_sticky", 8'(cfg_err), 8'h1);
        cfg_en = 1'b0;
        tick();
        check("recover_err",  8'(cfg_err),  8'h0);
        check("recover_done", 8'(cfg_done), 8'h1);

        // 5: lane0 PASS -> INV with a data edge on the commit cycle
        send_bits(16'h00E5, 8);
        cfg_en  = 1'b0;
        data_in = 4'b0100;
        tick();
        check("switch_old", 8'(data_out), 8'h2);
        check("switch_done", 8'(cfg_done), 8'h1);
        tick();
        check("switch_new", 8'(data_out), 8'h3);

        // 6: reset mid-frame discards the frame
        send_bits(16'h0000, 5);
        check("mid_busy", 8'(cfg_busy), 8'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_out",  8'(data_out), 8'h0);
        check("mid_rst_busy", 8'(cfg_busy), 8'h0);
        cfg_en  = 1'b0;
        data_in = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_mode0", 8'(data_out), 8'h3);
        data_in = 4'b1111;
        tick();
        check("mid_rst_mode1", 8'(data_out), 8'hC);
        send_bits(16'h0000, 8);
        cfg_en = 1'b0;
        tick();
        check("fresh_done", 8'(cfg_done), 8'h1);
        tick();
        check("fresh_pass", 8'(data_out), 8'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
